// File: rtl/d_mem_pipe.sv
// Single-port word memory behind a one-outstanding request/response pipe with READ_LAT read latency.
// Define DMEM_BOUNDS_CHECK_EN to reject word addresses >= DEPTH with rsp_err.
module d_mem_pipe #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned READ_LAT   = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_be,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    busy
);

   localparam int unsigned BE_W     = DATA_WIDTH / 8;
   localparam logic [1:0]  LAT_LOAD = 2'(READ_LAT - 1);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

   state_t                r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [1:0]            r_cnt;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_err;

   logic                  w_accept;
   logic                  w_in_range;
   logic                  w_bad;
   logic                  w_do_write;
   logic [DATA_WIDTH-1:0] w_rd_word;

   assign w_accept   = req_valid && (r_state == StIdle);
   assign w_in_range = 32'(req_addr) < DEPTH;
`ifdef DMEM_BOUNDS_CHECK_EN
   assign w_bad   = !w_in_range;
   assign rsp_err = r_err;
`else
   assign w_bad   = 1'b0;
   assign rsp_err = 1'b0;
`endif
   assign w_do_write = w_accept && req_write && w_in_range;

   // Single read port: the live request address in IDLE, the captured one while waiting.
   assign w_rd_word = r_mem[(r_state == StIdle) ? req_addr : r_addr];

   // Storage has no reset so committed writes survive rst_n.
   always_ff @(posedge clk) begin
      if (w_do_write) begin
         for (int b = 0; b < BE_W; b++) begin
            if (req_be[b]) r_mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle: begin
            if (w_accept) w_state_nxt = (req_write || READ_LAT == 1) ? StResp : StWait;
         end
         StWait: begin
            if (r_cnt == 2'd1) w_state_nxt = StResp;
         end
         StResp: begin
            if (rsp_ready) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_addr  <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_addr <= req_addr;
            r_err  <= w_bad;
            r_cnt  <= req_write ? 2'd0 : LAT_LOAD;
            if (req_write || w_bad || READ_LAT != 1) r_rdata <= '0;
            else                                     r_rdata <= w_rd_word;
         end else if (r_state == StWait) begin
            r_cnt <= r_cnt - 2'd1;
            if (r_cnt == 2'd1) r_rdata <= r_err ? '0 : w_rd_word;
         end
      end
   end

   assign req_ready = (r_state == StIdle);
   assign rsp_valid = (r_state == StResp);
   assign busy      = (r_state != StIdle);
   assign rsp_rdata = r_rdata;

endmodule

// File: doc/d_mem_pipe.md
D_MEM_PIPE -- requirements
Module: d_mem_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 256: number of words.
REQ-003 Parameter ADDR_WIDTH, default 8: word-address width; 2^ADDR_WIDTH >= DEPTH.
REQ-004 Parameter READ_LAT, default 1, range 1..4: cycles from read accept to rsp_valid.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  block can accept a request.
REQ-010 req_write  in  1  1 = write, 0 = read.
REQ-011 req_addr  in  ADDR_WIDTH  word address.
REQ-012 req_wdata  in  DATA_WIDTH  write data.
REQ-013 req_be  in  DATA_WIDTH/8  byte enables for writes; bit i covers bits 8i+7..8i.
REQ-014 rsp_valid  out  1  response present.
REQ-015 rsp_ready  in  1  consumer takes the response.
REQ-016 rsp_rdata  out  DATA_WIDTH  read data; 0 for write responses.
REQ-017 rsp_err  out  1  request was out of range (see Configuration).
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, WAIT, RESP; one request outstanding at a time.
REQ-020 req_ready SHALL be 1 only in IDLE; accept = req_valid & req_ready at a rising edge.
REQ-021 On a write accept, the word at req_addr SHALL be updated at that edge, only in bytes whose req_be bit is 1; FSM goes to RESP with rsp_rdata = 0.
REQ-022 A write with req_be = 0 SHALL leave memory unchanged and still produce a response.
REQ-023 On a read accept, address SHALL be captured; latency counter loads READ_LAT-1; FSM goes to WAIT, or straight to RESP if READ_LAT = 1.
REQ-024 In WAIT, the counter SHALL decrement each cycle; when it reaches 0, rsp_rdata is loaded from memory and FSM goes to RESP, so rsp_valid rises exactly READ_LAT cycles after the accept edge.
REQ-025 In RESP, rsp_valid = 1, and rsp_rdata/rsp_err SHALL hold stable until rsp_valid & rsp_ready; then the FSM goes to IDLE on that edge.
REQ-026 A new request SHALL NOT be accepted in the cycle of the response handshake; minimum spacing between accepts is READ_LAT+1 cycles for reads and 2 cycles for writes.
REQ-027 Read data SHALL reflect all writes accepted before the read's accept edge.
REQ-028 Address index SHALL be req_addr modulo 2^ADDR_WIDTH; behaviour for index >= DEPTH is defined only by REQ-034/035.

Reset
REQ-029 On rst_n low, the FSM SHALL go to IDLE immediately, with rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0, and the latency counter = 0.
REQ-030 req_ready SHALL be 1 during and after reset.
REQ-031 Memory contents SHALL NOT be cleared by reset; a write accepted before reset stays committed.
REQ-032 Reset asserted in WAIT or RESP SHALL abort the pending response with no rsp_valid pulse.

Configuration
REQ-033 Macro DMEM_BOUNDS_CHECK_EN SHALL enable bounds checking.
REQ-034 With DMEM_BOUNDS_CHECK_EN: a request with req_addr >= DEPTH SHALL not modify memory and SHALL respond with rsp_err = 1 and rsp_rdata = 0, using normal timing.
REQ-035 Without DMEM_BOUNDS_CHECK_EN: rsp_err SHALL be tied to 0 and an out-of-range index is a don't-care access with no error.

Verification
REQ-036 Reset, then write addr 5 data 0xDEADBEEF with be=0xF, then read addr 5 with READ_LAT=3 -> rsp_valid 3 cycles after accept, rdata 0xDEADBEEF, rsp_err 0.
REQ-037 Write 0xFFFFFFFF to addr 7, then write 0x12345678 with be=0x5, then read addr 7 -> 0xFF34FF78.
REQ-038 Read accepted with rsp_ready held 0 for 4 cycles -> rsp_valid and rsp_rdata stable, req_ready 0 and busy 1 throughout; IDLE the cycle after rsp_ready=1.
REQ-039 Pull rst_n low in WAIT after a read accept -> rsp_valid never rises; req_ready = 1; a prior write to addr 9 still reads back.
REQ-040 With DMEM_BOUNDS_CHECK_EN and DEPTH=200, ADDR_WIDTH=8: write addr 250 then read addr 250 -> both responses have rsp_err 1, rdata 0; addr 199 unaffected.
